bbg_shaper_mod: RTL and testbench

// Parametrised I/Q baseband shaper plus upconverter for the BBG chain. Sits between data_gen (i/q, cke, den) and the DAC outputs.

---
 rtl/bbg_pkg.sv | 51 +++++
 rtl/bbg_mac_lane.sv | 71 +++++++
 rtl/bbg_shaper_mod.sv | 184 ++++++++++++++++++
 tb/tb_bbg_shaper_mod.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbg_pkg.sv
// Shared types and arithmetic helpers for the BBG baseband chain.
package bbg_pkg;

    // Active shaping mode; the raw 2-bit code 3 decodes to MODE_RECT.
    typedef enum logic [1:0] {
        MODE_RECT = 2'd0,
        MODE_FIR  = 2'd1,
        MODE_MUTE = 2'd2
    } mode_t;

    // Shaper sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2
    } state_t;

    // Arithmetic right shift by sh (sh >= 1), rounding half up.
    function automatic logic signed [63:0] round_shr(input logic signed [63:0] x, input int sh);
        logic signed [63:0] half;
        half = 64'sd1 <<< (sh - 1);
        return (x + half) >>> sh;
    endfunction

    // Clamp x into the two's complement range of a w-bit signed value.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

    // Map the raw mode input onto the active-mode enum.
    function automatic mode_t decode_mode(input logic [1:0] m);
        mode_t r;
        case (m)
            2'd1:    r = MODE_FIR;
            2'd2:    r = MODE_MUTE;
            default: r = MODE_RECT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bbg_mac_lane.sv
// One shaping lane: symbol delay line, sequential MAC accumulator and
// the final round/saturate/mode selection of the shaped sample.
module bbg_mac_lane
    import bbg_pkg::*;
#(
    parameter int W        = 16,
    parameter int CW       = 16,
    parameter int SYM_SPAN = 5,
    parameter int SELW     = (SYM_SPAN > 1) ? $clog2(SYM_SPAN) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic                 clear_line,
    input  logic signed [W-1:0]  din,
    input  logic                 mac_en,
    input  logic                 mac_first,
    input  logic [SELW-1:0]      mac_sel,
    input  logic signed [CW-1:0] tap,
    input  mode_t                act_mode,
    output logic signed [W-1:0]  result
);

    localparam int ACCW = W + CW + $clog2(SYM_SPAN);

    logic signed [W-1:0]      sym [SYM_SPAN];
    logic signed [W-1:0]      sym_sel;
    logic signed [W+CW-1:0]   prod;
    logic signed [ACCW-1:0]   acc;
    logic signed [63:0]       acc_ext;
    logic signed [W-1:0]      fir_val;

    assign sym_sel = sym[mac_sel];
    assign prod    = sym_sel * tap;
    assign acc_ext = 64'(acc);
    assign fir_val = W'(sat_w(round_shr(acc_ext, CW - 2), W));

    // Delay line: new symbol enters at index 0; a mode change flushes older symbols.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYM_SPAN; k++) begin
                sym[k] <= '0;
            end
        end else if (shift_en) begin
            sym[0] <= din;
            for (int k = 1; k < SYM_SPAN; k++) begin
                sym[k] <= clear_line ? '0 : sym[k-1];
            end
        end
    end

    // Accumulator: restarts on the first MAC step, adds one product per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (mac_en) begin
            acc <= (mac_first ? '0 : acc) + ACCW'(prod);
        end
    end

    // Select the shaped value for the active mode.
    always_comb begin
        result = '0;
        case (act_mode)
            MODE_FIR:  result = fir_val;
            MODE_MUTE: result = '0;
            default:   result = sym[0];
        endcase
    end

endmodule

// File: rtl/bbg_shaper_mod.sv
// I/Q baseband shaper and upconverter: sequencing FSM, phase counter,
// shared tap RAM, two MAC lanes and the LO mixer.
module bbg_shaper_mod
    import bbg_pkg::*;
#(
    parameter int W        = 16,
    parameter int CW       = 16,
    parameter int OSR      = 8,
    parameter int SYM_SPAN = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cke,
    input  logic                               den,
    input  logic [1:0]                         mode,
    input  logic signed [W-1:0]                i_in,
    input  logic signed [W-1:0]                q_in,
    input  logic signed [W-1:0]                lo_i,
    input  logic signed [W-1:0]                lo_q,
    input  logic                               coef_we,
    input  logic [$clog2(SYM_SPAN*OSR)-1:0]    coef_addr,
    input  logic signed [CW-1:0]               coef_data,
    input  logic                               ovr_clr,
    output logic signed [W-1:0]                i_out,
    output logic signed [W-1:0]                q_out,
    output logic                               dvalid,
    output logic signed [W-1:0]                mod_out,
    output logic                               mvalid,
    output logic                               busy,
    output logic                               ovr
);

    localparam int NTAP = SYM_SPAN * OSR;
    localparam int AW   = $clog2(NTAP);
    localparam int PW   = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int CNTW = (SYM_SPAN > 1) ? $clog2(SYM_SPAN) : 1;

    // Power-up tap content: unity impulse at the centre symbol, phase 0.
    function automatic logic [NTAP*CW-1:0] tap_init();
        logic [NTAP*CW-1:0] r;
        r = '0;
        r[((SYM_SPAN / 2) * OSR) * CW +: CW] = {{(CW-1){1'b0}}, 1'b1} << (CW - 2);
        return r;
    endfunction

    localparam logic [NTAP*CW-1:0] TAP_INIT = tap_init();

    logic [NTAP-1:0][CW-1:0] taps = TAP_INIT;

    state_t                 state;
    logic [CNTW-1:0]        cnt;
    logic [PW-1:0]          phase;
    mode_t                  act_mode;
    mode_t                  new_mode;
    logic                   shift_en;
    logic                   clear_line;
    logic                   mac_en;
    logic                   mac_first;
    logic [AW-1:0]          rd_addr;
    logic signed [CW-1:0]   tap_rd;
    logic signed [W-1:0]    lane_i;
    logic signed [W-1:0]    lane_q;
    logic signed [2*W-1:0]  p_i;
    logic signed [2*W-1:0]  p_q;
    logic signed [2*W:0]    mix;
    logic signed [W-1:0]    mod_val;

    assign new_mode   = decode_mode(mode);
    assign shift_en   = (state == ST_IDLE) && cke && den;
    assign clear_line = shift_en && (new_mode != act_mode);
    assign mac_en     = (state == ST_MAC);
    assign mac_first  = (cnt == '0);
    assign rd_addr    = AW'(cnt) * AW'(OSR) + AW'(phase);
    assign tap_rd     = taps[rd_addr];

    // Tap RAM write port; the combinational read sees the pre-write value this cycle.
    always_ff @(posedge clk) begin
        if (coef_we && ({1'b0, coef_addr} < (AW+1)'(NTAP))) begin
            taps[coef_addr] <= coef_data;
        end
    end

    bbg_mac_lane #(.W(W), .CW(CW), .SYM_SPAN(SYM_SPAN), .SELW(CNTW)) u_lane_i (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (shift_en),
        .clear_line (clear_line),
        .din        (i_in),
        .mac_en     (mac_en),
        .mac_first  (mac_first),
        .mac_sel    (cnt),
        .tap        (tap_rd),
        .act_mode   (act_mode),
        .result     (lane_i)
    );

    bbg_mac_lane #(.W(W), .CW(CW), .SYM_SPAN(SYM_SPAN), .SELW(CNTW)) u_lane_q (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (shift_en),
        .clear_line (clear_line),
        .din        (q_in),
        .mac_en     (mac_en),
        .mac_first  (mac_first),
        .mac_sel    (cnt),
        .tap        (tap_rd),
        .act_mode   (act_mode),
        .result     (lane_q)
    );

    // Sequencer: accept strobes in IDLE, run SYM_SPAN MAC steps, then publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            phase    <= '0;
            act_mode <= MODE_RECT;
            busy     <= 1'b0;
            dvalid   <= 1'b0;
            i_out    <= '0;
            q_out    <= '0;
            ovr      <= 1'b0;
        end else begin
            dvalid <= 1'b0;
            if (cke && busy) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (cke) begin
                        state <= ST_MAC;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        if (den) begin
                            phase    <= '0;
                            act_mode <= new_mode;
                        end else if (phase != PW'(OSR - 1)) begin
                            phase <= phase + PW'(1);
                        end
                    end
                end
                ST_MAC: begin
                    if (cnt == CNTW'(SYM_SPAN - 1)) begin
                        state <= ST_ROUND;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                ST_ROUND: begin
                    i_out  <= lane_i;
                    q_out  <= lane_q;
                    dvalid <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign p_i     = i_out * lo_i;
    assign p_q     = q_out * lo_q;
    assign mix     = $signed({p_i[2*W-1], p_i}) + $signed({p_q[2*W-1], p_q});
    assign mod_val = W'(sat_w(round_shr(64'(mix), W - 1), W));

    // Mixer output register, one clock behind the shaped I/Q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mod_out <= '0;
            mvalid  <= 1'b0;
        end else begin
            mvalid <= dvalid;
            if (dvalid) begin
                mod_out <= mod_val;
            end
        end
    end

endmodule

// File: tb/tb_bbg_shaper_mod.sv
// Self-checking bench for bbg_shaper_mod: scoreboard queues for shaped and
// modulated samples, one task per scenario.
module tb_bbg_shaper_mod;

    localparam int SYM_SPAN = 5;
    localparam int OSR      = 8;
    localparam int NTAP     = SYM_SPAN * OSR;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cke = 1'b0;
    logic               den = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic signed [15:0] i_in = '0;
    logic signed [15:0] q_in = '0;
    logic signed [15:0] lo_i = '0;
    logic signed [15:0] lo_q = '0;
    logic               coef_we = 1'b0;
    logic [5:0]         coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic               ovr_clr = 1'b0;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;
    logic               dvalid;
    logic signed [15:0] mod_out;
    logic               mvalid;
    logic               busy;
    logic               ovr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic signed [15:0] ei;
        logic signed [15:0] eq;
        int                 edge_no;
    } exp_t;

    exp_t               exp_q[$];
    logic signed [15:0] mod_q[$];
    exp_t               mon_e;
    logic signed [15:0] mon_m;

    bbg_shaper_mod #(.W(16), .CW(16), .OSR(OSR), .SYM_SPAN(SYM_SPAN)) dut (
        .clk       (clk),
        .rst       (rst),
        .cke       (cke),
        .den       (den),
        .mode      (mode),
        .i_in      (i_in),
        .q_in      (q_in),
        .lo_i      (lo_i),
        .lo_q      (lo_q),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .ovr_clr   (ovr_clr),
        .i_out     (i_out),
        .q_out     (q_out),
        .dvalid    (dvalid),
        .mod_out   (mod_out),
        .mvalid    (mvalid),
        .busy      (busy),
        .ovr       (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected modulated sample from the expected shaped I/Q and the LO.
    function automatic logic signed [15:0] mod_model(input int ei, input int eq, input int li, input int lq);
        longint m;
        m = longint'(ei) * longint'(li) + longint'(eq) * longint'(lq);
        m = (m + 64'sd16384) >>> 15;
        if (m > 64'sd32767) m = 64'sd32767;
        else if (m < -64'sd32768) m = -64'sd32768;
        return 16'(m);
    endfunction

    // Output monitor: pops the scoreboards whenever the DUT publishes a sample.
    always @(negedge clk) begin
        if (!rst) begin
            if (mvalid) begin
                checks++;
                if (mod_q.size() == 0) begin
                    errors++;
                    $display("FAIL mvalid_unexpected: mod_out=%0d with nothing expected", mod_out);
                end else begin
                    mon_m = mod_q.pop_front();
                    if (mod_out !== mon_m) begin
                        errors++;
                        $display("FAIL mod_out: got %0d expected %0d", mod_out, mon_m);
                    end
                end
            end
            if (dvalid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dvalid_unexpected: i_out=%0d q_out=%0d with nothing expected", i_out, q_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (i_out !== mon_e.ei || q_out !== mon_e.eq) begin
                        errors++;
                        $display("FAIL iq_out: got %0d/%0d expected %0d/%0d", i_out, q_out, mon_e.ei, mon_e.eq);
                    end
                    checks++;
                    if (cyc - mon_e.edge_no != SYM_SPAN + 1) begin
                        errors++;
                        $display("FAIL latency: got %0d clks expected %0d", cyc - mon_e.edge_no, SYM_SPAN + 1);
                    end
                    mod_q.push_back(mod_model(mon_e.ei, mon_e.eq, lo_i, lo_q));
                end
            end
        end
    end

    // One accepted strobe followed by idle clocks up to the minimum spacing.
    task automatic strobe(input logic d, input int iv, input int qv, input logic [1:0] m,
                          input bit expect_out, input int ei, input int eq);
        @(negedge clk);
        cke  = 1'b1;
        den  = d;
        i_in = 16'(iv);
        q_in = 16'(qv);
        mode = m;
        if (expect_out) exp_q.push_back('{16'(ei), 16'(eq), cyc + 1});
        @(negedge clk);
        cke = 1'b0;
        den = 1'b0;
        repeat (SYM_SPAN) @(negedge clk);
    endtask

    task automatic load_taps(input int kind);
        for (int n = 0; n < NTAP; n++) begin
            @(negedge clk);
            coef_we   = 1'b1;
            coef_addr = 6'(n);
            coef_data = (kind == 0) ? 16'(100 * n) : 16'sd16384;
        end
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mod_q.size() != 0) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || mod_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d iq and %0d mod outputs missing, expected 0", name, exp_q.size(), mod_q.size());
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (i_out !== 16'sd0 || q_out !== 16'sd0 || mod_out !== 16'sd0) begin
            errors++;
            $display("FAIL reset_data: got %0d/%0d/%0d expected 0/0/0", i_out, q_out, mod_out);
        end
        checks++;
        if ({dvalid, mvalid, busy, ovr} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {dvalid, mvalid, busy, ovr});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rect();
        lo_i = 16'sd12000;
        lo_q = -16'sd7000;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < OSR; p++) begin
                strobe(p == 0, 1000, -1000, 2'd0, 1'b1, 1000, -1000);
            end
        end
        strobe(1'b1, 1500, -1500, 2'd3, 1'b1, 1500, -1500);
        strobe(1'b0, 0, 0, 2'd3, 1'b1, 1500, -1500);
        drain("rect");
    endtask

    task automatic test_fir_impulse();
        int n;
        int e;
        load_taps(0);
        lo_i = 16'sd16384;
        lo_q = 16'sd0;
        for (int s = 0; s < 6; s++) begin
            for (int p = 0; p < OSR; p++) begin
                n = s * OSR + p;
                if (n < NTAP + 2) begin
                    e = (n < NTAP) ? 100 * n : 0;
                    strobe(p == 0, (s == 0) ? 16384 : 0, (s == 0) ? -16384 : 0, 2'd1, 1'b1, e, -e);
                end
            end
        end
        drain("fir");
    endtask

    task automatic test_mode_switch();
        lo_i = -16'sd20000;
        lo_q = 16'sd9000;
        strobe(1'b1, 5000, 5000, 2'd0, 1'b1, 5000, 5000);
        strobe(1'b0, 0, 0, 2'd0, 1'b1, 5000, 5000);
        for (int p = 0; p < OSR; p++) begin
            strobe(p == 0, 16384, 16384, 2'd1, 1'b1, 100 * p, 100 * p);
        end
        strobe(1'b1, 0, 0, 2'd1, 1'b1, 800, 800);
        strobe(1'b0, 0, 0, 2'd1, 1'b1, 900, 900);
        strobe(1'b1, 3000, 3000, 2'd2, 1'b1, 0, 0);
        strobe(1'b1, 2500, -2500, 2'd0, 1'b1, 2500, -2500);
        drain("mode_switch");
    endtask

    task automatic test_saturation();
        load_taps(1);
        lo_i = 16'sd32767;
        lo_q = 16'sd0;
        for (int s = 0; s < SYM_SPAN + 1; s++) begin
            strobe(1'b1, 32767, -32768, 2'd1, 1'b1, 32767, -32768);
        end
        drain("saturation");
    endtask

    task automatic test_overrun();
        lo_i = 16'sd1000;
        lo_q = 16'sd1000;
        @(negedge clk);
        cke = 1'b1; den = 1'b1; i_in = 16'sd2000; q_in = -16'sd2000; mode = 2'd0;
        exp_q.push_back('{16'sd2000, -16'sd2000, cyc + 1});
        @(negedge clk);
        cke = 1'b0; den = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_set: got %b expected 1", busy);
        end
        @(negedge clk);
        @(negedge clk);
        cke = 1'b1; den = 1'b1; i_in = 16'sd3000; q_in = 16'sd3000;
        @(negedge clk);
        cke = 1'b0; den = 1'b0;
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set: got %b expected 1", ovr);
        end
        repeat (4) @(negedge clk);
        strobe(1'b0, 0, 0, 2'd0, 1'b1, 2000, -2000);
        drain("overrun_hold");
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: got %b expected 1", ovr);
        end
        @(negedge clk);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clr: got %b expected 0", ovr);
        end
        @(negedge clk);
        cke = 1'b1; den = 1'b0;
        exp_q.push_back('{16'sd2000, -16'sd2000, cyc + 1});
        @(negedge clk);
        cke = 1'b0;
        @(negedge clk);
        cke = 1'b1; ovr_clr = 1'b1;
        @(negedge clk);
        cke = 1'b0; ovr_clr = 1'b0;
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_priority: got %b expected 1", ovr);
        end
        drain("overrun_prio");
    endtask

    task automatic test_reset_mid_mac();
        @(negedge clk);
        cke = 1'b1; den = 1'b1; i_in = 16'sd7000; q_in = 16'sd7000; mode = 2'd0;
        @(negedge clk);
        cke = 1'b0; den = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ovr !== 1'b1 || i_out === 16'sd0) begin
            errors++;
            $display("FAIL pre_reset_state: busy=%b ovr=%b i_out=%0d expected busy=1 ovr=1 i_out!=0", busy, ovr, i_out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (i_out !== 16'sd0 || q_out !== 16'sd0 || mod_out !== 16'sd0) begin
            errors++;
            $display("FAIL mid_reset_data: got %0d/%0d/%0d expected 0/0/0", i_out, q_out, mod_out);
        end
        checks++;
        if ({dvalid, mvalid, busy, ovr} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_flags: got %b expected 0000", {dvalid, mvalid, busy, ovr});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (i_out !== 16'sd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_discard: i_out=%0d busy=%b expected 0/0", i_out, busy);
        end
    endtask

    initial begin
        test_reset();
        test_rect();
        test_fir_impulse();
        test_mode_switch();
        test_saturation();
        test_overrun();
        test_reset_mid_mac();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
